// File: rtl/apb_regbank_gen.sv
// apb_regbank_gen: parametrised register bank behind the APB slave Reg* handshake.
// Supports configurable depth, width and wait states.
// Read-only registers are sourced live from HwIN.
// Errors are reported on RegSLVERR, and every RW register is exported on RegQ.
// Optional feature macro: REGBANK_STRB_EN adds the RegSTRB byte-strobe port.
module apb_regbank_gen #(
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  ADDR_WIDTH  = 32,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [ADDR_WIDTH-1:0]          RegADDR,
    input  logic [DATA_WIDTH-1:0]          RegWDATA,
    input  logic                           RegWRITE,
    input  logic                           RegENABLE,
`ifdef REGBANK_STRB_EN
    input  logic [DATA_WIDTH/8-1:0]        RegSTRB,
`endif
    input  logic [NUM_REGS*DATA_WIDTH-1:0] HwIN,
    output logic [DATA_WIDTH-1:0]          RegRDATA,
    output logic                           RegSLVERR,
    output logic                           RegREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] RegQ
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int ALIGN  = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W  = 4;

    // Low address bits that must be zero for an aligned access (empty for 8-bit data).
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ALIGN) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
    localparam logic [CNT_W-1:0]      WAIT_INIT  = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic                    latch_s;
    logic                    commit_s;

    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic                    write_r;
    logic [STRB_W-1:0]       strb_r;
    logic [STRB_W-1:0]       strb_in_s;

    logic [ADDR_WIDTH-1:0]   req_addr_s;
    logic [DATA_WIDTH-1:0]   req_wdata_s;
    logic                    req_write_s;
    logic [STRB_W-1:0]       req_strb_s;

    logic [ADDR_WIDTH-1:0]   idx_full_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    misalign_s;
    logic                    out_range_s;
    logic                    ro_s;
    logic                    err_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;
    logic [NUM_REGS-1:0]     wr_en_s;

    logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    slverr_r;
    logic                    ready_r;

`ifdef REGBANK_STRB_EN
    assign strb_in_s = RegSTRB;
`else
    assign strb_in_s = {STRB_W{1'b1}};
`endif

    // Next-state and wait-counter logic; a request is only accepted in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (RegENABLE) begin
                    latch_s = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = WAIT_INIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // The access completes on the edge that enters RESP; with zero wait states that is the accept edge.
    assign commit_s = (state_nxt_s == ST_RESP);

    // Request source: live bus while idle (zero-wait commit), latched copy afterwards.
    always_comb begin
        if (state_r == ST_IDLE) begin
            req_addr_s  = RegADDR;
            req_wdata_s = RegWDATA;
            req_write_s = RegWRITE;
            req_strb_s  = strb_in_s;
        end else begin
            req_addr_s  = addr_r;
            req_wdata_s = wdata_r;
            req_write_s = write_r;
            req_strb_s  = strb_r;
        end
    end

    // Address decode and error classification over the full address width.
    always_comb begin
        idx_full_s  = req_addr_s >> ALIGN;
        idx_s       = idx_full_s[IDX_W-1:0];
        misalign_s  = ((req_addr_s & ALIGN_MASK) != {ADDR_WIDTH{1'b0}});
        out_range_s = (idx_full_s >= NUM_REGS_A);
        if (out_range_s) begin
            ro_s = 1'b0;
        end else begin
            ro_s = RO_MASK[idx_s];
        end
        err_s = misalign_s | out_range_s | (req_write_s & ro_s);
    end

    // Read mux: RO registers return the live HwIN slice, RW registers their stored value.
    always_comb begin
        rd_word_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!out_range_s && (idx_s == IDX_W'(i))) begin
                if (RO_MASK[i]) begin
                    rd_word_s = HwIN[i*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    rd_word_s = regs_r[i];
                end
            end else begin
                rd_word_s = rd_word_s;
            end
        end
    end

    // Per-register write enable, only for a committing error-free write.
    always_comb begin
        wr_en_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_s && req_write_s && !err_s && (idx_s == IDX_W'(i))) begin
                wr_en_s[i] = 1'b1;
            end else begin
                wr_en_s[i] = 1'b0;
            end
        end
    end

    // FSM state and wait counter registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Capture the request at accept so WAIT cycles ignore the bus.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            addr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r <= {DATA_WIDTH{1'b0}};
            write_r <= 1'b0;
            strb_r  <= {STRB_W{1'b0}};
        end else if (latch_s) begin
            addr_r  <= RegADDR;
            wdata_r <= RegWDATA;
            write_r <= RegWRITE;
            strb_r  <= strb_in_s;
        end
    end

    // Response outputs: one-cycle READY, error flag, read data held between reads.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ready_r  <= 1'b0;
            slverr_r <= 1'b0;
            rdata_r  <= {DATA_WIDTH{1'b0}};
        end else if (commit_s) begin
            ready_r  <= 1'b1;
            slverr_r <= err_s;
            if (err_s) begin
                rdata_r <= {DATA_WIDTH{1'b0}};
            end else if (!req_write_s) begin
                rdata_r <= rd_word_s;
            end
        end else begin
            ready_r  <= 1'b0;
            slverr_r <= 1'b0;
        end
    end

    // Register storage with byte-granular update.
    always_ff @(posedge PCLK) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (PRESET) begin
                    regs_r[i][b*8 +: 8] <= 8'd0;
                end else if (wr_en_s[i] && req_strb_s[b]) begin
                    regs_r[i][b*8 +: 8] <= req_wdata_s[b*8 +: 8];
                end
            end
        end
    end

    // Export RW registers; RO slices read as zero.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
        if (RO_MASK[g]) begin : g_ro
            assign RegQ[g*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
        end else begin : g_rw
            assign RegQ[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
        end
    end

    assign RegREADY  = ready_r;
    assign RegSLVERR = slverr_r;
    assign RegRDATA  = rdata_r;

endmodule

// File: tb/tb_apb_regbank_gen.sv
// Scoreboard bench for apb_regbank_gen (32-bit, 16 regs, 3 wait states, reg 6 read-only).
module tb_apb_regbank_gen;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 16;
    localparam int WS = 3;

    logic           PCLK = 1'b0;
    logic           PRESET;
    logic [AW-1:0]  RegADDR;
    logic [DW-1:0]  RegWDATA;
    logic           RegWRITE;
    logic           RegENABLE;
    logic [3:0]     RegSTRB;
    logic [NR*DW-1:0] HwIN;
    logic [DW-1:0]  RegRDATA;
    logic           RegSLVERR;
    logic           RegREADY;
    logic [NR*DW-1:0] RegQ;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_ready = 1'b0;

    apb_regbank_gen #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR),
        .WAIT_STATES(WS),
        .RO_MASK    (16'h0040)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .RegADDR  (RegADDR),
        .RegWDATA (RegWDATA),
        .RegWRITE (RegWRITE),
        .RegENABLE(RegENABLE),
`ifdef REGBANK_STRB_EN
        .RegSTRB  (RegSTRB),
`endif
        .HwIN     (HwIN),
        .RegRDATA (RegRDATA),
        .RegSLVERR(RegSLVERR),
        .RegREADY (RegREADY),
        .RegQ     (RegQ)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every READY pulse pops one expected response.
    always @(negedge PCLK) begin
        if (RegREADY === 1'b1) begin
            chk("ready_single_cycle", {63'd0, prev_ready}, 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: got READY at cycle %0d expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rdata", {32'd0, RegRDATA}, {32'd0, mon_e.rdata});
                chk("slverr", {63'd0, RegSLVERR}, {63'd0, mon_e.err});
                chk("latency", 64'(cyc - mon_e.cyc), 64'(WS + 1));
            end
        end
        prev_ready <= RegREADY;
    end

    // One access: drive ENABLE for a cycle, scramble the bus, wait (bounded) for READY.
    task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        @(negedge PCLK);
        RegADDR   = addr;
        RegWDATA  = wdata;
        RegWRITE  = wr;
        RegSTRB   = strb;
        RegENABLE = 1'b1;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cyc   = cyc;
        exp_q.push_back(e);
        @(negedge PCLK);
        RegENABLE = 1'b0;
        RegADDR   = 32'hFFFF_FFFC;
        RegWDATA  = 32'h0BAD_0BAD;
        RegWRITE  = ~wr;
        RegSTRB   = 4'h0;
        n = 0;
        while (RegREADY !== 1'b1 && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        chk("ready_timeout", {63'd0, RegREADY}, 64'd1);
    endtask

    logic [31:0] exp_strb_word;

    initial begin
        PRESET    = 1'b1;
        RegADDR   = 32'd0;
        RegWDATA  = 32'd0;
        RegWRITE  = 1'b0;
        RegENABLE = 1'b0;
        RegSTRB   = 4'hF;
        HwIN      = '0;
`ifdef REGBANK_STRB_EN
        exp_strb_word = 32'h11BB_33DD;
`else
        exp_strb_word = 32'hAABB_CCDD;
`endif
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        chk("reset_ready", {63'd0, RegREADY}, 64'd0);
        chk("reset_rdata", {32'd0, RegRDATA}, 64'd0);
        chk("reset_slverr", {63'd0, RegSLVERR}, 64'd0);
        chk("reset_regq", 64'(RegQ == '0), 64'd1);

        // All registers read zero after reset.
        for (int i = 0; i < NR; i++) begin
            do_access(1'b0, 32'(i * 4), 32'd0, 4'hF, 32'd0, 1'b0);
        end

        // Write then read back through the wait states.
        do_access(1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
        do_access(1'b0, 32'h08, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0);
        chk("regq_reg2", {32'd0, RegQ[2*32 +: 32]}, {32'd0, 32'hDEAD_BEEF});

        // Misaligned, out-of-range, and far-out address errors.
        do_access(1'b0, 32'h41, 32'd0, 4'hF, 32'd0, 1'b1);
        do_access(1'b0, 32'h40, 32'd0, 4'hF, 32'd0, 1'b1);
        do_access(1'b0, 32'h0000_1008, 32'd0, 4'hF, 32'd0, 1'b1);
        do_access(1'b1, 32'h0A, 32'h0000_0055, 4'hF, 32'd0, 1'b1);
        do_access(1'b1, 32'h40, 32'h0000_0077, 4'hF, 32'd0, 1'b1);
        do_access(1'b0, 32'h08, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0);
        chk("regq_reg0_untouched", {32'd0, RegQ[0 +: 32]}, 64'd0);

        // Read-only register 6 sourced from HwIN.
        HwIN[6*32 +: 32] = 32'h0000_1234;
        do_access(1'b1, 32'h18, 32'h0000_FFFF, 4'hF, 32'd0, 1'b1);
        do_access(1'b0, 32'h18, 32'd0, 4'hF, 32'h0000_1234, 1'b0);
        chk("regq_ro_zero", {32'd0, RegQ[6*32 +: 32]}, 64'd0);

        // Last register boundary.
        do_access(1'b1, 32'h3C, 32'hA5A5_A5A5, 4'hF, 32'h0000_1234, 1'b0);
        do_access(1'b0, 32'h3C, 32'd0, 4'hF, 32'hA5A5_A5A5, 1'b0);

        // Byte strobes (full-word update when strobes are not built in).
        do_access(1'b1, 32'h0C, 32'h1122_3344, 4'hF, 32'hA5A5_A5A5, 1'b0);
        do_access(1'b1, 32'h0C, 32'hAABB_CCDD, 4'b0101, 32'hA5A5_A5A5, 1'b0);
        do_access(1'b0, 32'h0C, 32'd0, 4'hF, exp_strb_word, 1'b0);
`ifdef REGBANK_STRB_EN
        do_access(1'b1, 32'h0C, 32'hFFFF_FFFF, 4'h0, exp_strb_word, 1'b0);
        do_access(1'b0, 32'h0C, 32'd0, 4'hF, exp_strb_word, 1'b0);
`endif
        chk("regq_reg3", {32'd0, RegQ[3*32 +: 32]}, {32'd0, exp_strb_word});

        // Reset during WAIT of a write: no READY, write dropped.
        @(negedge PCLK);
        RegADDR   = 32'h04;
        RegWDATA  = 32'hCAFE_F00D;
        RegWRITE  = 1'b1;
        RegSTRB   = 4'hF;
        RegENABLE = 1'b1;
        @(negedge PCLK);
        RegENABLE = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        chk("rst_wait_ready", {63'd0, RegREADY}, 64'd0);
        chk("rst_wait_rdata", {32'd0, RegRDATA}, 64'd0);
        repeat (8) @(negedge PCLK);
        chk("rst_wait_regq", 64'(RegQ == '0), 64'd1);
        do_access(1'b0, 32'h04, 32'd0, 4'hF, 32'd0, 1'b0);
        do_access(1'b0, 32'h08, 32'd0, 4'hF, 32'd0, 1'b0);

        repeat (4) @(negedge PCLK);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
